// File: rtl/q_row_fetch.sv
// Fetches one Q-table row (ACTIONS words of a state) from the synchronous RAM,
// one action per cycle, and presents it as a packed row with a one-cycle valid pulse.
module q_row_fetch #(
   parameter int DATA_WIDTH    = 32,
   parameter int ACTIONS       = 4,
   parameter int ACTIONS_WIDTH = 2,
   parameter int STATE_WIDTH   = 4
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                i_valid,
   input  logic [STATE_WIDTH-1:0]              i_state,
   output logic                                o_ram_rd_en,
   output logic [STATE_WIDTH+ACTIONS_WIDTH-1:0] o_ram_addr,
   input  logic [DATA_WIDTH-1:0]               i_ram_data,
   output logic [DATA_WIDTH*ACTIONS-1:0]       o_data,
   output logic [STATE_WIDTH-1:0]              o_state,
   output logic                                o_valid,
   output logic                                o_busy
);

   localparam int ROW_W  = DATA_WIDTH * ACTIONS;
   localparam int ADDR_W = STATE_WIDTH + ACTIONS_WIDTH;
   localparam logic [ACTIONS_WIDTH-1:0] LAST_ACT = ACTIONS_WIDTH'(ACTIONS - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      WAIT = 2'd2
   } state_e;

   state_e                    state_q, state_d;
   logic [STATE_WIDTH-1:0]    st_q, st_d;
   logic [ACTIONS_WIDTH-1:0]  cnt_q, cnt_d;
   logic [ACTIONS_WIDTH-1:0]  cnt_inc;
   logic                      rd_en_q, rd_en_d;
   logic [ADDR_W-1:0]         addr_q, addr_d;
   logic                      cap_en_q, cap_en_d;
   logic [ACTIONS_WIDTH-1:0]  cap_idx_q, cap_idx_d;
   logic [ROW_W-1:0]          row_buf_q, row_buf_d;
   logic [ROW_W-1:0]          data_q, data_d;
   logic [STATE_WIDTH-1:0]    ostate_q, ostate_d;
   logic                      valid_q, valid_d;
   logic                      busy_q, busy_d;

   // Request handshake: i_valid is a strobe with no ready; it is accepted only
   // on an edge where the FSM is IDLE and dropped otherwise. o_valid is a
   // one-cycle pulse with no back-pressure; o_data/o_state hold until the next one.
   always_comb begin
      state_d   = state_q;
      st_d      = st_q;
      cnt_d     = cnt_q;
      cnt_inc   = cnt_q + 1'b1;
      rd_en_d   = 1'b0;
      addr_d    = addr_q;
      data_d    = data_q;
      ostate_d  = ostate_q;
      valid_d   = 1'b0;

      // Read data returns one cycle after the read edge, so the lane index
      // travels alongside it through a one-cycle delay.
      cap_en_d  = rd_en_q;
      cap_idx_d = addr_q[ACTIONS_WIDTH-1:0];

      row_buf_d = row_buf_q;
      if (cap_en_q) begin
         for (int k = 0; k < ACTIONS; k++) begin
            if (cap_idx_q == ACTIONS_WIDTH'(k)) begin
               row_buf_d[k*DATA_WIDTH +: DATA_WIDTH] = i_ram_data;
            end
         end
      end

      case (state_q)
         IDLE: begin
            if (i_valid) begin
               st_d    = i_state;
               cnt_d   = '0;
               rd_en_d = 1'b1;
               addr_d  = {i_state, {ACTIONS_WIDTH{1'b0}}};
               state_d = READ;
            end
         end
         READ: begin
            if (cnt_q == LAST_ACT) begin
               state_d = WAIT;
            end else begin
               cnt_d   = cnt_inc;
               rd_en_d = 1'b1;
               addr_d  = {st_q, cnt_inc};
            end
         end
         WAIT: begin
            // The last lane lands in this edge; publish the buffer including it.
            data_d   = row_buf_d;
            ostate_d = st_q;
            valid_d  = 1'b1;
            state_d  = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         st_q      <= '0;
         cnt_q     <= '0;
         rd_en_q   <= 1'b0;
         addr_q    <= '0;
         cap_en_q  <= 1'b0;
         cap_idx_q <= '0;
         row_buf_q <= '0;
         data_q    <= '0;
         ostate_q  <= '0;
         valid_q   <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         st_q      <= st_d;
         cnt_q     <= cnt_d;
         rd_en_q   <= rd_en_d;
         addr_q    <= addr_d;
         cap_en_q  <= cap_en_d;
         cap_idx_q <= cap_idx_d;
         row_buf_q <= row_buf_d;
         data_q    <= data_d;
         ostate_q  <= ostate_d;
         valid_q   <= valid_d;
         busy_q    <= busy_d;
      end
   end

   assign o_ram_rd_en = rd_en_q;
   assign o_ram_addr  = addr_q;
   assign o_data      = data_q;
   assign o_state     = ostate_q;
   assign o_valid     = valid_q;
   assign o_busy      = busy_q;

endmodule

// File: tb/tb_q_row_fetch.sv
// Bench for q_row_fetch: a synchronous RAM model, a timing-level reference model of
// the fetch sequence, a per-cycle compare process and directed + random scenarios.
module tb_q_row_fetch;

   localparam int DW = 32;
   localparam int A  = 4;
   localparam int AW = 2;
   localparam int SW = 4;
   localparam int RW = DW * A;

   logic          clk;
   logic          rst_n;
   logic          i_valid;
   logic [SW-1:0] i_state;
   logic          o_ram_rd_en;
   logic [SW+AW-1:0] o_ram_addr;
   logic [DW-1:0] i_ram_data;
   logic [RW-1:0] o_data;
   logic [SW-1:0] o_state;
   logic          o_valid;
   logic          o_busy;

   q_row_fetch #(
      .DATA_WIDTH(DW), .ACTIONS(A), .ACTIONS_WIDTH(AW), .STATE_WIDTH(SW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_state(i_state),
      .o_ram_rd_en(o_ram_rd_en), .o_ram_addr(o_ram_addr), .i_ram_data(i_ram_data),
      .o_data(o_data), .o_state(o_state), .o_valid(o_valid), .o_busy(o_busy)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // synchronous RAM: data valid one cycle after the read edge
   logic [DW-1:0] ram [64];
   logic [DW-1:0] ram_rd_q = '0;
   always @(posedge clk) if (o_ram_rd_en) ram_rd_q <= ram[o_ram_addr];
   assign i_ram_data = ram_rd_q;

   function automatic logic [RW-1:0] row_of(input int s);
      logic [RW-1:0] r;
      for (int k = 0; k < A; k++) r[DW*k +: DW] = ram[s*A + k];
      return r;
   endfunction

   // reference model: phase = edges elapsed since the accepting edge
   int            m_phase = -1;
   logic [SW-1:0] m_state = '0;
   logic          exp_rd_en = 1'b0, exp_busy = 1'b0, exp_valid = 1'b0;
   logic [SW+AW-1:0] exp_addr = '0;
   logic [RW-1:0] exp_data = '0;
   logic [SW-1:0] exp_state = '0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_phase = -1; m_state = '0;
         exp_rd_en = 1'b0; exp_busy = 1'b0; exp_valid = 1'b0;
         exp_addr = '0; exp_data = '0; exp_state = '0;
      end else begin
         if (m_phase < 0 || m_phase == A + 1) begin
            if (i_valid) begin
               m_phase = 0;
               m_state = i_state;
            end else begin
               m_phase = -1;
            end
         end else begin
            m_phase++;
         end
         exp_rd_en = (m_phase >= 0) && (m_phase < A);
         if (exp_rd_en) exp_addr = 6'(int'(m_state) * A + m_phase);
         exp_busy  = (m_phase >= 0) && (m_phase <= A);
         exp_valid = (m_phase == A + 1);
         if (exp_valid) begin
            exp_data  = row_of(int'(m_state));
            exp_state = m_state;
         end
      end
   end

   // scoreboard: address log plus every-cycle compare against the model
   logic [SW+AW-1:0] addr_log[$];
   always @(negedge clk) begin
      if (o_ram_rd_en) addr_log.push_back(o_ram_addr);
      check("rd_en", RW'(o_ram_rd_en), RW'(exp_rd_en));
      if (exp_rd_en) check("ram_addr", RW'(o_ram_addr), RW'(exp_addr));
      check("busy", RW'(o_busy), RW'(exp_busy));
      check("valid", RW'(o_valid), RW'(exp_valid));
      check("data", o_data, exp_data);
      check("state", RW'(o_state), RW'(exp_state));
   end

   // driver tasks
   task automatic fetch(input logic [SW-1:0] s, output int lat);
      @(negedge clk);
      i_valid = 1'b1;
      i_state = s;
      lat = 0;
      for (int n = 1; n <= 20; n++) begin
         @(negedge clk);
         i_valid = 1'b0;
         if (o_valid) begin
            lat = n;
            break;
         end
      end
   endtask

   task automatic wait_valid(output int n_out);
      n_out = 0;
      for (int n = 1; n <= 20; n++) begin
         @(negedge clk);
         if (o_valid) begin
            n_out = n;
            break;
         end
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_rd_en"}, RW'(o_ram_rd_en), '0);
      check({tag, "_addr"}, RW'(o_ram_addr), '0);
      check({tag, "_data"}, o_data, '0);
      check({tag, "_state"}, RW'(o_state), '0);
      check({tag, "_valid"}, RW'(o_valid), '0);
      check({tag, "_busy"}, RW'(o_busy), '0);
   endtask

   initial begin
      int lat;
      int gap;
      logic [SW-1:0] exp_s;

      rst_n = 1'b0;
      i_valid = 1'b0;
      i_state = '0;
      for (int i = 0; i < 64; i++) ram[i] = $urandom;
      for (int k = 0; k < A; k++) ram[3*A + k] = 32'h10 + 32'(k);
      ram[60] = 32'hFFFFFFFF;
      ram[61] = 32'h00000000;
      ram[62] = 32'h80000000;
      ram[63] = 32'h7FFFFFFF;

      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // basic fetch of state 3
      addr_log.delete();
      fetch(4'd3, lat);
      check("basic_latency", RW'(lat), RW'(A + 2));
      check("basic_data", o_data, 128'h00000013_00000012_00000011_00000010);
      check("basic_state", RW'(o_state), RW'(3));
      check("basic_nreads", RW'(addr_log.size()), RW'(A));
      for (int k = 0; k < A; k++)
         check("basic_addr", RW'((k < addr_log.size()) ? addr_log[k] : 6'h3F), RW'(8'h0C + k));
      repeat (3) @(negedge clk);

      // request held during a fetch is ignored, then accepted in the o_valid cycle
      addr_log.delete();
      @(negedge clk);
      i_valid = 1'b1;
      i_state = 4'd3;
      @(negedge clk);
      i_state = 4'd5;
      wait_valid(lat);
      check("ign_first_lat", RW'(lat + 1), RW'(A + 2));
      check("ign_first_state", RW'(o_state), RW'(3));
      check("ign_first_data", o_data, 128'h00000013_00000012_00000011_00000010);
      gap = 0;
      for (int n = 1; n <= 20; n++) begin
         @(negedge clk);
         if (n == 1) i_valid = 1'b0;
         if (o_valid) begin
            gap = n;
            break;
         end
      end
      check("ign_gap", RW'(gap), RW'(A + 2));
      check("ign_second_state", RW'(o_state), RW'(5));
      check("ign_nreads", RW'(addr_log.size()), RW'(2 * A));
      repeat (3) @(negedge clk);

      // back-to-back, alternating states 1 and 2
      @(negedge clk);
      i_valid = 1'b1;
      i_state = 4'd1;
      exp_s = 4'd1;
      for (int p = 0; p < 6; p++) begin
         wait_valid(gap);
         check("b2b_gap", RW'(gap), RW'(A + 2));
         check("b2b_state", RW'(o_state), RW'(exp_s));
         exp_s = (exp_s == 4'd1) ? 4'd2 : 4'd1;
         i_state = exp_s;
         if (p == 5) i_valid = 1'b0;
      end
      repeat (4) @(negedge clk);

      // reset in the middle of a fetch
      @(negedge clk);
      i_valid = 1'b1;
      i_state = 4'd2;
      @(posedge clk);
      @(negedge clk);
      i_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1 check_all_zero("async_reset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      check("post_reset_data", o_data, '0);
      fetch(4'd3, lat);
      check("post_reset_latency", RW'(lat), RW'(A + 2));
      check("post_reset_data_row", o_data, 128'h00000013_00000012_00000011_00000010);
      repeat (2) @(negedge clk);

      // boundary data at the maximum state
      addr_log.delete();
      fetch(4'd15, lat);
      check("bnd_latency", RW'(lat), RW'(A + 2));
      check("bnd_data", o_data, 128'h7FFFFFFF_80000000_00000000_FFFFFFFF);
      check("bnd_state", RW'(o_state), RW'(15));
      for (int k = 0; k < A; k++)
         check("bnd_addr", RW'((k < addr_log.size()) ? addr_log[k] : 6'h00), RW'(8'h3C + k));
      repeat (2) @(negedge clk);

      // random requests; the compare process checks every cycle
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         i_valid = ($urandom_range(0, 2) != 0);
         i_state = SW'($urandom_range(0, 15));
      end
      @(negedge clk);
      i_valid = 1'b0;
      repeat (10) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
